// File: rtl/control_step_sequencer.sv
// Control step sequencer: step counter with run/halt control, one-hot step
// decode, and translation of the current step into the operational signal
// vector through a run-time writable step-to-signal table.
module control_step_sequencer #(
    parameter int STEPS   = 256,
    parameter int CNT_W   = 8,
    parameter int SIG_W   = 64,
    parameter int OUT_REG = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stall,
    input  logic             clr,
    input  logic             br_valid,
    input  logic [CNT_W-1:0] br_target,
    input  logic             halt,
    input  logic             tbl_we,
    input  logic [CNT_W-1:0] tbl_addr,
    input  logic [SIG_W-1:0] tbl_data,
    output logic [CNT_W-1:0] step,
    output logic [STEPS-1:0] T,
    output logic [SIG_W-1:0] signals,
    output logic [CNT_W-1:0] sig_step,
    output logic             sig_valid,
    output logic             run,
    output logic             err
);

    // Index width covering every legal step; the step register never holds
    // a value >= STEPS, so the low bits alone address table and T.
    localparam int IDX_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CNT_W:0]   STEPS_EXT = (CNT_W + 1)'(STEPS);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);
    localparam logic [CNT_W-1:0] STEP_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  step_q, step_d;
    logic              err_q, err_d;
    logic              run_s;
    logic              br_oor_s;
    logic              tbl_oor_s;
    logic [SIG_W-1:0]  rd_row_s;
    logic [SIG_W-1:0]  sig_row_s;
    logic [STEPS-1:0]  t_s;
    logic [SIG_W-1:0]  tbl_q [STEPS];

    assign run_s     = (state_q == ST_RUN);
    assign br_oor_s  = ({1'b0, br_target} >= STEPS_EXT);
    assign tbl_oor_s = ({1'b0, tbl_addr} >= STEPS_EXT);
    // Combinational read of the old row: a same-cycle write lands at the edge.
    assign rd_row_s  = tbl_q[step_q[IDX_W-1:0]];

    // Next state, next step and sticky error evaluation
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (clr) begin
                    step_d = '0;
                end else if (br_valid) begin
                    if (br_oor_s) begin
                        step_d = '0;
                        err_d  = 1'b1;
                    end else begin
                        step_d = br_target;
                    end
                end else if (stall) begin
                    step_d = step_q;
                end else if (step_q == LAST_STEP) begin
                    step_d = '0;
                end else begin
                    step_d = step_q + STEP_ONE;
                end
                // The step update above still applies in a halting cycle.
                if (halt) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_HALT: begin
                if (start) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_HALT;
                end
            end
            default: begin
                state_d = ST_IDLE;
                step_d  = '0;
            end
        endcase
        if (tbl_we && tbl_oor_s) begin
            err_d = 1'b1;
        end else begin
            err_d = err_d;
        end
    end

    // Control state, step counter and sticky error registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            step_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            err_q   <= err_d;
        end
    end

    // Step-to-signal table writes; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (tbl_we && !tbl_oor_s) begin
            tbl_q[tbl_addr[IDX_W-1:0]] <= tbl_data;
        end
    end

    // One-hot step decode and gated table row, both silent outside RUN
    always_comb begin
        t_s       = '0;
        sig_row_s = '0;
        if (run_s) begin
            t_s[step_q[IDX_W-1:0]] = 1'b1;
            sig_row_s              = rd_row_s;
        end else begin
            t_s       = '0;
            sig_row_s = '0;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [SIG_W-1:0] signals_q;
            logic [CNT_W-1:0] sig_step_q;
            logic             sig_valid_q;

            // Translated row registered one cycle behind the step it belongs to
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    signals_q   <= '0;
                    sig_step_q  <= '0;
                    sig_valid_q <= 1'b0;
                end else begin
                    signals_q   <= sig_row_s;
                    sig_step_q  <= step_q;
                    sig_valid_q <= run_s;
                end
            end

            assign signals   = signals_q;
            assign sig_step  = sig_step_q;
            assign sig_valid = sig_valid_q;
        end else begin : g_out_comb
            assign signals   = sig_row_s;
            assign sig_step  = step_q;
            assign sig_valid = run_s;
        end
    endgenerate

    assign step = step_q;
    assign T    = t_s;
    assign run  = run_s;
    assign err  = err_q;

endmodule

// File: tb/tb_control_step_sequencer.sv
// Scoreboard bench for control_step_sequencer: a registered-output 256-step
// instance (A) and a combinational-output 8-step instance (B).
module tb_control_step_sequencer;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Instance A: STEPS=256, CNT_W=9 (so 300 is expressible), OUT_REG=1
    logic         start_a, stall_a, clr_a, br_valid_a, halt_a, tbl_we_a;
    logic [8:0]   br_target_a, tbl_addr_a, step_a, sig_step_a;
    logic [63:0]  tbl_data_a, signals_a;
    logic [255:0] T_a;
    logic         sig_valid_a, run_a, err_a;

    control_step_sequencer #(.STEPS(256), .CNT_W(9), .SIG_W(64), .OUT_REG(1)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .stall(stall_a), .clr(clr_a),
        .br_valid(br_valid_a), .br_target(br_target_a), .halt(halt_a),
        .tbl_we(tbl_we_a), .tbl_addr(tbl_addr_a), .tbl_data(tbl_data_a),
        .step(step_a), .T(T_a), .signals(signals_a), .sig_step(sig_step_a),
        .sig_valid(sig_valid_a), .run(run_a), .err(err_a)
    );

    // Instance B: STEPS=8, CNT_W=4, OUT_REG=0
    logic         start_b, stall_b, clr_b, br_valid_b, halt_b, tbl_we_b;
    logic [3:0]   br_target_b, tbl_addr_b, step_b, sig_step_b;
    logic [15:0]  tbl_data_b, signals_b;
    logic [7:0]   T_b;
    logic         sig_valid_b, run_b, err_b;

    control_step_sequencer #(.STEPS(8), .CNT_W(4), .SIG_W(16), .OUT_REG(0)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .stall(stall_b), .clr(clr_b),
        .br_valid(br_valid_b), .br_target(br_target_b), .halt(halt_b),
        .tbl_we(tbl_we_b), .tbl_addr(tbl_addr_b), .tbl_data(tbl_data_b),
        .step(step_b), .T(T_b), .signals(signals_b), .sig_step(sig_step_b),
        .sig_valid(sig_valid_b), .run(run_b), .err(err_b)
    );

    logic [63:0] shadow_a [256];
    logic [15:0] shadow_b [8];
    logic [72:0] qa [$];
    logic [19:0] qb [$];
    logic        prev_run_a = 1'b0;
    logic        exp_err_a  = 1'b0;
    logic        exp_err_b  = 1'b0;

    function automatic logic [63:0] rowval_a(input int k);
        if (k < 4) return 64'h8000_0000_0000_0001 << k;
        return {32'hA5A5_0000 | 32'(k), 32'h5A5A_0000 ^ 32'(k)};
    endfunction

    function automatic logic [15:0] rowval_b(input int k);
        return 16'h0F0F ^ (16'(k) * 16'h1111);
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One cycle of instance A: check state outputs, queue the expected row.
    task automatic cyc_a(input int s, input logic r);
        logic [255:0] et;
        @(negedge clk);
        et = '0;
        if (r) et[s] = 1'b1;
        check("a_step", 256'(step_a), 256'(s));
        check("a_run", 256'(run_a), 256'(r));
        check("a_T", T_a, et);
        check("a_err", 256'(err_a), 256'(exp_err_a));
        check("a_sig_valid", 256'(sig_valid_a), 256'(prev_run_a));
        if (!prev_run_a) check("a_idle_signals", 256'(signals_a), 256'(0));
        if (r) qa.push_back({9'(s), shadow_a[s]});
        prev_run_a = r;
        @(posedge clk);
        #1;
    endtask

    // One cycle of instance B (combinational outputs belong to this cycle).
    task automatic cyc_b(input int s, input logic r);
        logic [255:0] et;
        if (r) qb.push_back({4'(s), shadow_b[s]});
        @(negedge clk);
        et = '0;
        if (r) et[s] = 1'b1;
        check("b_step", 256'(step_b), 256'(s));
        check("b_run", 256'(run_b), 256'(r));
        check("b_T", 256'(T_b), et);
        check("b_err", 256'(err_b), 256'(exp_err_b));
        check("b_sig_valid", 256'(sig_valid_b), 256'(r));
        if (!r) check("b_idle_signals", 256'(signals_b), 256'(0));
        @(posedge clk);
        #1;
    endtask

    // Monitor: pop and compare whenever a DUT presents valid signals
    always @(negedge clk) begin
        if (rst_n && sig_valid_a) begin
            if (qa.size() == 0) begin
                total++; bad++;
                $display("FAIL a_sb_empty: got sig_valid=1 step=%0d expected no output", sig_step_a);
            end else begin
                logic [72:0] it;
                it = qa.pop_front();
                check("a_sb_step", 256'(sig_step_a), 256'(it[72:64]));
                check("a_sb_signals", 256'(signals_a), 256'(it[63:0]));
            end
        end
        if (rst_n && sig_valid_b) begin
            if (qb.size() == 0) begin
                total++; bad++;
                $display("FAIL b_sb_empty: got sig_valid=1 step=%0d expected no output", sig_step_b);
            end else begin
                logic [19:0] it;
                it = qb.pop_front();
                check("b_sb_step", 256'(sig_step_b), 256'(it[19:16]));
                check("b_sb_signals", 256'(signals_b), 256'(it[15:0]));
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        {start_a, stall_a, clr_a, br_valid_a, halt_a, tbl_we_a} = 6'b0;
        br_target_a = 9'd0; tbl_addr_a = 9'd0; tbl_data_a = 64'd0;
        {start_b, stall_b, clr_b, br_valid_b, halt_b, tbl_we_b} = 6'b0;
        br_target_b = 4'd0; tbl_addr_b = 4'd0; tbl_data_b = 16'd0;

        // Reset values
        @(negedge clk);
        check("a_rst_step", 256'(step_a), 256'(0));
        check("a_rst_T", T_a, 256'(0));
        check("a_rst_signals", 256'(signals_a), 256'(0));
        check("a_rst_sig_step", 256'(sig_step_a), 256'(0));
        check("a_rst_sig_valid", 256'(sig_valid_a), 256'(0));
        check("a_rst_run", 256'(run_a), 256'(0));
        check("a_rst_err", 256'(err_a), 256'(0));
        check("b_rst_step", 256'(step_b), 256'(0));
        check("b_rst_T", 256'(T_b), 256'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Program rows 0..63 of A
        for (int k = 0; k < 64; k++) begin
            tbl_we_a = 1'b1; tbl_addr_a = 9'(k); tbl_data_a = rowval_a(k);
            shadow_a[k] = rowval_a(k);
            cyc_a(0, 1'b0);
        end
        tbl_we_a = 1'b0;

        // Start, count 0..4, overwrite row 3 while it is being read
        start_a = 1'b1; cyc_a(0, 1'b0); start_a = 1'b0;
        cyc_a(0, 1'b1); cyc_a(1, 1'b1); cyc_a(2, 1'b1);
        tbl_we_a = 1'b1; tbl_addr_a = 9'd3; tbl_data_a = 64'hDEAD_BEEF_0000_0003;
        cyc_a(3, 1'b1);
        tbl_we_a = 1'b0; shadow_a[3] = 64'hDEAD_BEEF_0000_0003;
        cyc_a(4, 1'b1);

        // Stall three cycles at step 5
        stall_a = 1'b1;
        repeat (3) cyc_a(5, 1'b1);
        stall_a = 1'b0;
        cyc_a(5, 1'b1); cyc_a(6, 1'b1); cyc_a(7, 1'b1); cyc_a(8, 1'b1);

        // clr beats br_valid, then branch 42, then out-of-range branch 300
        clr_a = 1'b1; br_valid_a = 1'b1; br_target_a = 9'd42;
        cyc_a(9, 1'b1);
        clr_a = 1'b0;
        cyc_a(0, 1'b1);
        br_valid_a = 1'b0;
        cyc_a(42, 1'b1);
        br_valid_a = 1'b1; br_target_a = 9'd300;
        cyc_a(43, 1'b1);
        br_valid_a = 1'b0; exp_err_a = 1'b1;
        cyc_a(0, 1'b1);

        // Revisit row 3: new contents now
        br_valid_a = 1'b1; br_target_a = 9'd3; cyc_a(1, 1'b1);
        br_valid_a = 1'b0; cyc_a(3, 1'b1);

        // Halt at 12: step advances to 13, run drops, signals clear a cycle later
        br_valid_a = 1'b1; br_target_a = 9'd12; cyc_a(4, 1'b1);
        br_valid_a = 1'b0;
        halt_a = 1'b1; cyc_a(12, 1'b1); halt_a = 1'b0;
        cyc_a(13, 1'b0);
        start_a = 1'b1; cyc_a(13, 1'b0); start_a = 1'b0;
        cyc_a(13, 1'b1); cyc_a(14, 1'b1);

        // halt wins over start; clr/branch/stall ignored while halted
        halt_a = 1'b1; start_a = 1'b1; cyc_a(15, 1'b1);
        halt_a = 1'b0; start_a = 1'b0;
        clr_a = 1'b1; br_valid_a = 1'b1; br_target_a = 9'd5; stall_a = 1'b1;
        cyc_a(16, 1'b0); cyc_a(16, 1'b0);
        clr_a = 1'b0; br_valid_a = 1'b0; stall_a = 1'b0;
        start_a = 1'b1; cyc_a(16, 1'b0); start_a = 1'b0;
        cyc_a(16, 1'b1); cyc_a(17, 1'b1);

        // Asynchronous reset mid-RUN (step 18), away from any clock edge
        #2;
        rst_n = 1'b0;
        #1;
        check("a_arst_step", 256'(step_a), 256'(0));
        check("a_arst_T", T_a, 256'(0));
        check("a_arst_run", 256'(run_a), 256'(0));
        check("a_arst_signals", 256'(signals_a), 256'(0));
        check("a_arst_sig_valid", 256'(sig_valid_a), 256'(0));
        check("a_arst_sig_step", 256'(sig_step_a), 256'(0));
        check("a_arst_err", 256'(err_a), 256'(0));
        qa.delete();
        prev_run_a = 1'b0;
        exp_err_a  = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Instance B: program 8 rows, then an out-of-range table write
        for (int k = 0; k < 8; k++) begin
            tbl_we_b = 1'b1; tbl_addr_b = 4'(k); tbl_data_b = rowval_b(k);
            shadow_b[k] = rowval_b(k);
            cyc_b(0, 1'b0);
        end
        tbl_we_b = 1'b1; tbl_addr_b = 4'd9; tbl_data_b = 16'hFFFF;
        cyc_b(0, 1'b0);
        tbl_we_b = 1'b0; exp_err_b = 1'b1;

        // Run through the wrap 7 -> 0, stall, halt
        start_b = 1'b1; cyc_b(0, 1'b0); start_b = 1'b0;
        for (int k = 0; k < 8; k++) cyc_b(k, 1'b1);
        cyc_b(0, 1'b1); cyc_b(1, 1'b1);
        stall_b = 1'b1; cyc_b(2, 1'b1); stall_b = 1'b0;
        cyc_b(2, 1'b1);
        halt_b = 1'b1; cyc_b(3, 1'b1); halt_b = 1'b0;
        cyc_b(4, 1'b0);

        // Every queued expectation must have been consumed
        total++;
        if (qa.size() != 0 || qb.size() != 0) begin
            bad++;
            $display("FAIL sb_drain: got %0d/%0d entries left expected 0/0", qa.size(), qb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/control_step_sequencer.md
Name: control_step_sequencer

Overview:
- Parametrised successor to the hardwired-control translate stage of the picoRISC control unit.
- Holds the control step counter and generates the one-hot T vector from it.
- Translates the current step into the operational signal vector through a run-time writable step-to-signal table, so the hardwired OR-equations are no longer needed.
- Adds run/halt control, stall, branch/clear of the step counter and optional output registering.

Parameters:
- STEPS, 256, number of control steps. Range 2..2^CNT_W.
- CNT_W, 8, step counter width.
- SIG_W, 64, operational signal vector width.
- OUT_REG, 1, 1 = signals/sig_step registered (+1 cycle); 0 = combinational from current step.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  IDLE/HALT -> RUN request.
- stall  in  1  hold step counter (memory wait, e.g. rdCPU/wrCPU not done).
- clr  in  1  step := 0 (new fetch).
- br_valid  in  1  load step from br_target.
- br_target  in  CNT_W  branch step.
- halt  in  1  RUN -> HALT.
- tbl_we  in  1  table write strobe.
- tbl_addr  in  CNT_W  table row.
- tbl_data  in  SIG_W  row contents; bit SIG_W-1 maps to the first signal (ldMAR) position.
- step  out  CNT_W  current step.
- T  out  STEPS  one-hot decode of step; all-zero when not RUN.
- signals  out  SIG_W  operational signals for sig_step.
- sig_step  out  CNT_W  step that produced signals.
- sig_valid  out  1  signals correspond to a RUN step.
- run  out  1  state == RUN.
- err  out  1  sticky: out-of-range branch target or table address.

Behaviour:
- Reset (async, rst_n=0) sets:
  - state = IDLE, step = 0, T = 0, signals = 0, sig_step = 0, sig_valid = 0, err = 0.
  - Table contents are not reset; software/boot FSM programs them before start.
- States and transitions:
  - IDLE: start -> RUN.
  - RUN: halt -> HALT (takes priority over start).
  - HALT: start -> RUN.
  - In IDLE/HALT, step holds and clr/br_valid/stall are ignored.
- Step update in RUN, one per cycle, priority clr > br_valid > stall > increment:
  - clr: step := 0.
  - br_valid: step := br_target. If br_target >= STEPS, step := 0 and err := 1.
  - stall: hold.
  - Increment: step := step+1, wrapping STEPS-1 -> 0.
  - halt in the same cycle as a step update: the update still applies, then the state becomes HALT.
- Mid-run reset: asynchronously returns everything to the reset values above within the same cycle.
- T: T[step] = 1 when run=1; otherwise 0. Combinational from the step register.
- Translation, OUT_REG=0:
  - signals = table[step] when run; else 0.
  - sig_step = step; sig_valid = run.
- Translation, OUT_REG=1:
  - signals/sig_step/sig_valid are registered one cycle after the step they belong to.
  - In the cycle after leaving RUN: signals = 0, sig_valid = 0.
- Table writes:
  - A write when tbl_we=1 takes effect at the clock edge.
  - A read of the same row in the same cycle returns the old data (read-before-write).
  - tbl_addr >= STEPS: write ignored, err := 1.
- Stall: signals repeat the held step's row every cycle; sig_valid stays 1.
- err is cleared only by reset.

Test Plan:
- Reset, program rows 0..3 = 64'h8000...0001 << k, start, no stall -> step 0,1,2,3 on consecutive cycles; T = 1,2,4,8; signals (OUT_REG=1) lag step by exactly 1 cycle with matching sig_step.
- At step 5, assert stall for 3 cycles -> step stays 5 for 4 cycles total; signals = row 5 repeated; sig_valid = 1 throughout.
- clr and br_valid (target 42) asserted together at step 9 -> next step = 0. br_valid alone with target 42 -> step = 42. Target 300 with STEPS=256 -> step = 0, err = 1.
- STEPS=8, run to step 7 with no stall -> next step 0, T = 8'b0000_0001.
- halt at step 12 -> step 13, run = 0, T = 0; signals = 0 on the following cycle. start -> resumes at 13.
- Write row 3 while step = 3: signals show the old row this cycle, the new row on the next visit. Deassert rst_n mid-RUN -> step = 0, T = 0, state IDLE immediately (asynchronous).
